scmp_bus_cycle: RTL and testbench
=================================

// Module: scmp_bus_cycle
// PURPOSE
//  Bus-cycle controller downstream of the microcode sequencer. Takes its one-cycle strobe
//  requests (ADS/RD/WR, active low) and status flags (R,I,D,H); runs a timed external SC/MP
//  cycle: bus request/grant, address strobe with status on DB, read/write strobe with NHOLD
//  extension. Returns a stall to the sequencer and captured read data to the datapath.
// PARAMETERS
//  STRB_CYC  2  min cycles NRDS/NWDS held low (>=1)
//  ADDR_W   16  address width; DB carries addr[15:12] during ADS
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous, active-high reset
//  mc_ads_n      in   1   cycle request from microcode, active low, one clock wide
//  mc_rd_n       in   1   read request, active low, qualifies mc_ads_n
//  mc_wr_n       in   1   write request, active low, qualifies mc_ads_n
//  mc_flags      in   4   {H,D,I,R} status flags, valid with mc_ads_n
//  addr_in       in   16  address from datapath, valid with mc_ads_n
//  wr_data       in   8   write data, valid with mc_ads_n
//  stall         out  1   hold microcode PC while high
//  rd_data       out  8   captured read data
//  rd_valid      out  1   one-clock pulse, rd_data valid
//  req_err       out  1   one-clock pulse: illegal request (RD and WR both low)
//  bus_ENIN      in   1   bus grant, active high
//  bus_NHOLD_n   in   1   wait request, active low
//  bus_BREQ      out  1   bus request
//  bus_NADS_n    out  1   address strobe
//  bus_NRDS_n    out  1   read strobe
//  bus_NWDS_n    out  1   write strobe
//  bus_addr      out  12  address [11:0]
//  bus_db_out    out  8   data bus drive
//  bus_db_oe     out  1   data bus output enable
//  bus_db_in     in   8   data bus input
// BEHAVIOUR
//  Reset: state IDLE; strobes high; BREQ/db_oe/stall/rd_valid/req_err 0; rd_data, addr, db_out 0.
//  Accept: mc_ads_n low in IDLE or DONE -> latch addr, flags, wr_data, dir; ignored otherwise.
//   Dir: RD low->read; WR low->write; neither->address-only; both->read + req_err pulse.
//  stall = accept | state in {WAITBUS,ADDR,STRB}; combinational; low in IDLE and DONE.
//  FSM (all strobes registered):
//   IDLE/DONE --accept--> WAITBUS (BREQ=1)
//   WAITBUS: bus_ENIN=1 -> ADDR; else stay (no strobes, stall high, unbounded)
//   ADDR (1 clk): NADS_n=0; db_out={H,D,I,R,addr[15:12]}, db_oe=1
//     -> STRB if read/write; address-only -> DONE
//   STRB: NRDS_n or NWDS_n=0; counter loads STRB_CYC-1, decrements;
//     at count 0 with NHOLD_n=1 -> DONE; NHOLD_n=0 extends one clk per clock
//     write: db_out=wr_data, db_oe=1; read: db_oe=0; bus_db_in captured at STRB exit
//   DONE (1 clk): strobes high; write data/db_oe held (hold time); rd_valid=1 if read;
//     BREQ dropped unless accept -> WAITBUS
//  bus_addr stable WAITBUS..DONE.
//  Latency, read, ENIN=1, no hold: req c0 -> WAITBUS c1, ADDR c2, STRB c3..c2+STRB_CYC,
//   DONE c3+STRB_CYC; stall high c0..c2+STRB_CYC.
//  ENIN dropped mid-cycle: ignored once ADDR entered; cycle completes.
//  rst mid-cycle: strobes high, db_oe 0, IDLE at the next edge; latched request discarded.
// STRUCTURE
//  Package scmp_bus_pkg: state enum (IDLE,WAITBUS,ADDR,STRB,DONE), dir enum (RD,WR,ADR),
//   flag bit indices FLG_R=0..FLG_H=3, DB status layout constants.
//  Sub-module scmp_bus_strobe_timer: loadable down-counter, NHOLD-gated, 'expire' output.
// TESTING
//  Read 0x1234, flags 4'b0101, ENIN=1, NHOLD_n=1, db_in=0xA5 -> NADS low at c2 with
//   db_out=0x51, NRDS low c3-c4, rd_valid+rd_data=0xA5 at c5, stall high c0-c4.
//  Write 0x0FFE data 0x3C, NHOLD_n low 3 clk in STRB -> NWDS low 5 clk; db_out=0x3C
//   through DONE; no rd_valid.
//  ENIN=0 for 4 clk after request -> BREQ high, no strobes, stall held; ENIN=1 -> normal.
//  RD_n and WR_n both low -> req_err pulse, read cycle runs.
//  Back-to-back: new request in DONE -> BREQ stays high, WAITBUS next clk.
//  rst asserted in STRB -> all strobes high, db_oe 0, stall 0 after next edge.

Source files
------------

// File: rtl/scmp_bus_pkg.sv
// Shared types and constants for the SC/MP bus-cycle controller.
// The status byte placed on DB during the address strobe is built here.
package scmp_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAITBUS,
    ADDR,
    STRB,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RD,
    WR,
    ADR
  } dir_e;

  localparam int FLG_R = 0;
  localparam int FLG_I = 1;
  localparam int FLG_D = 2;
  localparam int FLG_H = 3;

  // DB layout during ADS: flags in the upper nibble, addr[15:12] in the lower.
  localparam int DB_ADDR_LSB = 0;
  localparam int DB_FLG_LSB  = 4;

  function automatic logic [7:0] status_byte(input logic [3:0] flags,
                                             input logic [3:0] addr_hi);
    logic [7:0] b;
    b = '0;
    b[DB_FLG_LSB + FLG_R]  = flags[FLG_R];
    b[DB_FLG_LSB + FLG_I]  = flags[FLG_I];
    b[DB_FLG_LSB + FLG_D]  = flags[FLG_D];
    b[DB_FLG_LSB + FLG_H]  = flags[FLG_H];
    b[DB_ADDR_LSB +: 4]    = addr_hi;
    return b;
  endfunction

endpackage

// File: rtl/scmp_bus_strobe_timer.sv
// Strobe-width down-counter: loaded on strobe entry, decremented only while
// NHOLD_n is high, so each wait-request clock stretches the strobe by one.
module scmp_bus_strobe_timer #(
  parameter int STRB_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic hold_n,
  output logic expire
);

  localparam int CNT_W = (STRB_CYC > 1) ? $clog2(STRB_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STRB_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (hold_n && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = (count == '0) && hold_n;

endmodule

// File: rtl/scmp_bus_cycle.sv
// SC/MP external bus-cycle controller: turns one-clock microcode strobe requests
// into a BREQ/ENIN, NADS, NRDS/NWDS sequence and stalls the sequencer meanwhile.
module scmp_bus_cycle
  import scmp_bus_pkg::*;
#(
  parameter int STRB_CYC = 2,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mc_ads_n,
  input  logic              mc_rd_n,
  input  logic              mc_wr_n,
  input  logic [3:0]        mc_flags,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        wr_data,
  output logic              stall,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              req_err,
  input  logic              bus_ENIN,
  input  logic              bus_NHOLD_n,
  output logic              bus_BREQ,
  output logic              bus_NADS_n,
  output logic              bus_NRDS_n,
  output logic              bus_NWDS_n,
  output logic [11:0]       bus_addr,
  output logic [7:0]        bus_db_out,
  output logic              bus_db_oe,
  input  logic [7:0]        bus_db_in,
  output state_e            dbg_state
);

  // Handshake: a request is taken only in the clock where mc_ads_n is low and
  // the controller is in IDLE or DONE; the sequencer must hold while stall=1.

  state_e            state, next_state;
  dir_e              dir_q, acc_dir;
  logic [3:0]        flags_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              accept, expire, tmr_load, rd_capture;
  logic              breq_d, nads_d, nrds_d, nwds_d, oe_d, rdv_d;
  logic [7:0]        dout_d;

  always_comb begin
    accept  = !rst && !mc_ads_n && ((state == IDLE) || (state == DONE));
    acc_dir = ADR;
    if (!mc_rd_n)      acc_dir = RD;
    else if (!mc_wr_n) acc_dir = WR;
    stall = accept || (state == WAITBUS) || (state == ADDR) || (state == STRB);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = accept ? WAITBUS : IDLE;
      WAITBUS:    if (bus_ENIN) next_state = ADDR;
      ADDR:       next_state = (dir_q == ADR) ? DONE : STRB;
      STRB:       if (expire) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  assign tmr_load   = (state == ADDR) && (next_state == STRB);
  assign rd_capture = (state == STRB) && expire && (dir_q == RD);

  // Bus outputs are registered from next_state so every strobe is glitch-free.
  always_comb begin
    breq_d = (next_state != IDLE);
    nads_d = (next_state != ADDR);
    nrds_d = !((next_state == STRB) && (dir_q == RD));
    nwds_d = !((next_state == STRB) && (dir_q == WR));
    rdv_d  = (state == STRB) && (next_state == DONE) && (dir_q == RD);
    oe_d   = 1'b0;
    dout_d = bus_db_out;
    case (next_state)
      ADDR: begin
        oe_d   = 1'b1;
        dout_d = status_byte(flags_q, addr_q[ADDR_W-1 -: 4]);
      end
      STRB, DONE: begin
        if (dir_q == WR) begin
          oe_d   = 1'b1;
          dout_d = wdata_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir_q      <= ADR;
      flags_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bus_BREQ   <= 1'b0;
      bus_NADS_n <= 1'b1;
      bus_NRDS_n <= 1'b1;
      bus_NWDS_n <= 1'b1;
      bus_db_out <= '0;
      bus_db_oe  <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        dir_q   <= acc_dir;
        flags_q <= mc_flags;
        addr_q  <= addr_in;
        wdata_q <= wr_data;
      end
      bus_BREQ   <= breq_d;
      bus_NADS_n <= nads_d;
      bus_NRDS_n <= nrds_d;
      bus_NWDS_n <= nwds_d;
      bus_db_out <= dout_d;
      bus_db_oe  <= oe_d;
      rd_valid   <= rdv_d;
      req_err    <= accept && !mc_rd_n && !mc_wr_n;
      if (rd_capture) rd_data <= bus_db_in;
    end
  end

  assign bus_addr  = addr_q[11:0];
  assign dbg_state = state;

  scmp_bus_strobe_timer #(
    .STRB_CYC(STRB_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .hold_n (bus_NHOLD_n),
    .expire (expire)
  );

endmodule

// File: tb/tb_scmp_bus_cycle.sv
// Bench for scmp_bus_cycle: per-cycle stimulus tables, a timeline model of the
// bus cycle built from request/ENIN/NHOLD rules, and per-cycle trace comparison.
module tb_scmp_bus_cycle;
  import scmp_bus_pkg::*;

  localparam int STRB_CYC = 2;
  localparam int N = 48;
  localparam int W = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mc_ads_n, mc_rd_n, mc_wr_n, bus_ENIN, bus_NHOLD_n;
  logic [3:0]  mc_flags;
  logic [15:0] addr_in;
  logic [7:0]  wr_data, bus_db_in;
  logic        stall, rd_valid, req_err, bus_BREQ, bus_NADS_n, bus_NRDS_n, bus_NWDS_n, bus_db_oe;
  logic [7:0]  rd_data, bus_db_out;
  logic [11:0] bus_addr;
  state_e      dbg_state;

  scmp_bus_cycle #(.STRB_CYC(STRB_CYC), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .mc_ads_n(mc_ads_n), .mc_rd_n(mc_rd_n), .mc_wr_n(mc_wr_n),
    .mc_flags(mc_flags), .addr_in(addr_in), .wr_data(wr_data), .stall(stall),
    .rd_data(rd_data), .rd_valid(rd_valid), .req_err(req_err), .bus_ENIN(bus_ENIN),
    .bus_NHOLD_n(bus_NHOLD_n), .bus_BREQ(bus_BREQ), .bus_NADS_n(bus_NADS_n),
    .bus_NRDS_n(bus_NRDS_n), .bus_NWDS_n(bus_NWDS_n), .bus_addr(bus_addr),
    .bus_db_out(bus_db_out), .bus_db_oe(bus_db_oe), .bus_db_in(bus_db_in),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  logic [W-1:0] obs_q[$];
  state_e       st_q[$];

  // stimulus tables, one entry per clock of a run
  logic        s_rst[N], s_ads_n[N], s_rd_n[N], s_wr_n[N], s_enin[N], s_nhold[N];
  logic [7:0]  s_dbin[N], s_wdata[N];
  logic [15:0] s_addr[N];
  logic [3:0]  s_flags[N];

  // expected per-cycle outputs
  logic        e_stall[N], e_breq[N], e_nads[N], e_nrds[N], e_nwds[N], e_oe[N];
  logic        e_rdv[N], e_rerr[N], e_av[N];
  logic [7:0]  e_dout[N], e_rd[N];
  logic [11:0] e_addr[N];
  logic [7:0]  rd_carry;

  function automatic logic [W-1:0] pack(input logic st, input logic br, input logic na,
                                        input logic nr, input logic nw, input logic oe,
                                        input logic [7:0] dout, input logic rv,
                                        input logic [7:0] rd, input logic re,
                                        input logic [11:0] ad);
    return {st, br, na, nr, nw, oe, dout, rv, rd, re, ad};
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < N; c++) begin
      s_rst[c]   = 1'b0;
      s_ads_n[c] = 1'b1;
      s_rd_n[c]  = 1'($urandom_range(0, 1));
      s_wr_n[c]  = 1'($urandom_range(0, 1));
      s_enin[c]  = (c >= 14) ? 1'b1 : 1'($urandom_range(0, 1));
      s_nhold[c] = (c >= 26) ? 1'b1 : ($urandom_range(0, 3) != 0);
      s_dbin[c]  = 8'($urandom);
      s_wdata[c] = 8'($urandom);
      s_addr[c]  = 16'($urandom);
      s_flags[c] = 4'($urandom);
      e_stall[c] = 1'b0; e_breq[c] = 1'b0; e_nads[c] = 1'b1; e_nrds[c] = 1'b1;
      e_nwds[c]  = 1'b1; e_oe[c]   = 1'b0; e_rdv[c]  = 1'b0; e_rerr[c] = 1'b0;
      e_av[c]    = 1'b0; e_dout[c] = 8'h00; e_rd[c] = rd_carry; e_addr[c] = 12'h000;
    end
  endtask

  task automatic set_req(input int c0, input logic rd_n, input logic wr_n);
    s_ads_n[c0] = 1'b0;
    s_rd_n[c0]  = rd_n;
    s_wr_n[c0]  = wr_n;
  endtask

  // Timeline model: WAITBUS until ENIN seen, one ADDR clock, then a strobe lasting
  // STRB_CYC clocks with NHOLD high, then one DONE clock.
  task automatic model_txn(input int c0, output int done);
    int kind, c, rem, last;
    logic [11:0] a12;
    kind = !s_rd_n[c0] ? 0 : (!s_wr_n[c0] ? 1 : 2);
    a12  = s_addr[c0][11:0];
    e_stall[c0] = 1'b1;
    if (!s_rd_n[c0] && !s_wr_n[c0]) e_rerr[c0+1] = 1'b1;
    c = c0 + 1;
    forever begin
      e_stall[c] = 1'b1; e_breq[c] = 1'b1; e_av[c] = 1'b1; e_addr[c] = a12;
      if (s_enin[c] || c >= N - 10) break;
      c++;
    end
    c++;
    e_stall[c] = 1'b1; e_breq[c] = 1'b1; e_av[c] = 1'b1; e_addr[c] = a12;
    e_nads[c] = 1'b0; e_oe[c] = 1'b1; e_dout[c] = {s_flags[c0], s_addr[c0][15:12]};
    last = c;
    if (kind != 2) begin
      rem = STRB_CYC;
      c++;
      forever begin
        e_stall[c] = 1'b1; e_breq[c] = 1'b1; e_av[c] = 1'b1; e_addr[c] = a12;
        if (kind == 0) e_nrds[c] = 1'b0;
        else begin
          e_nwds[c] = 1'b0; e_oe[c] = 1'b1; e_dout[c] = s_wdata[c0];
        end
        if (s_nhold[c]) rem--;
        if (rem == 0 || c >= N - 4) break;
        c++;
      end
      last = c;
    end
    done = last + 1;
    e_breq[done] = 1'b1; e_av[done] = 1'b1; e_addr[done] = a12;
    if (kind == 1) begin
      e_oe[done] = 1'b1; e_dout[done] = s_wdata[c0];
    end
    if (kind == 0) begin
      e_rdv[done] = 1'b1;
      rd_carry = s_dbin[last];
      for (int k = done; k < N; k++) e_rd[k] = rd_carry;
    end
  endtask

  // Driver/monitor: applies the tables one clock at a time and records the trace.
  task automatic run_tables();
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      rst = s_rst[c]; mc_ads_n = s_ads_n[c]; mc_rd_n = s_rd_n[c]; mc_wr_n = s_wr_n[c];
      mc_flags = s_flags[c]; addr_in = s_addr[c]; wr_data = s_wdata[c];
      bus_ENIN = s_enin[c]; bus_NHOLD_n = s_nhold[c]; bus_db_in = s_dbin[c];
      #3;
      obs_q.push_back(pack(stall, bus_BREQ, bus_NADS_n, bus_NRDS_n, bus_NWDS_n, bus_db_oe,
                           bus_db_out, rd_valid, rd_data, req_err, bus_addr));
      st_q.push_back(dbg_state);
    end
    for (int c = 0; c < N; c++) begin
      exp_q.push_back(pack(e_stall[c], e_breq[c], e_nads[c], e_nrds[c], e_nwds[c], e_oe[c],
                           e_dout[c], e_rdv[c], e_rd[c], e_rerr[c], e_addr[c]));
      msk_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, e_oe[c] ? 8'hFF : 8'h00,
                           1'b1, 8'hFF, 1'b1, e_av[c] ? 12'hFFF : 12'h000));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mc_ads_n = 1'b1; mc_rd_n = 1'b1; mc_wr_n = 1'b1; mc_flags = 4'h0;
    addr_in = 16'h0; wr_data = 8'h0; bus_ENIN = 1'b0; bus_NHOLD_n = 1'b1; bus_db_in = 8'h0;
    repeat (3) @(posedge clk);
    #4;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (bus_BREQ !== 1'b0) begin failures++; $display("FAIL reset_breq got=%b exp=0", bus_BREQ); end
    checks++; if (bus_NADS_n !== 1'b1) begin failures++; $display("FAIL reset_nads got=%b exp=1", bus_NADS_n); end
    checks++; if (bus_NRDS_n !== 1'b1) begin failures++; $display("FAIL reset_nrds got=%b exp=1", bus_NRDS_n); end
    checks++; if (bus_NWDS_n !== 1'b1) begin failures++; $display("FAIL reset_nwds got=%b exp=1", bus_NWDS_n); end
    checks++; if (bus_db_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", bus_db_oe); end
    checks++; if (bus_db_out !== 8'h00) begin failures++; $display("FAIL reset_dbout got=%h exp=00", bus_db_out); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rddata got=%h exp=00", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rdvalid got=%b exp=0", rd_valid); end
    checks++; if (req_err !== 1'b0) begin failures++; $display("FAIL reset_reqerr got=%b exp=0", req_err); end
    checks++; if (bus_addr !== 12'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", bus_addr); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    rd_carry = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_read();
    int d;
    logic [W-1:0] o, e, m;
    clear_stim();
    for (int c = 0; c < N; c++) begin
      s_enin[c] = 1'b1; s_nhold[c] = 1'b1; s_dbin[c] = 8'hA5;
    end
    set_req(2, 1'b0, 1'b1);
    s_addr[2] = 16'h1234; s_flags[2] = 4'b0101;
    model_txn(2, d);
    run_tables();
    for (int c = 0; c < N; c++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++; $display("FAIL read cyc=%0d got=%h exp=%h", c, o & m, e & m);
      end
    end
    st_q.delete();
    checks++;
    if (rd_data !== 8'hA5) begin failures++; $display("FAIL read_data got=%h exp=a5", rd_data); end
  endtask

  task automatic test_write_hold();
    int d;
    logic [W-1:0] o, e, m;
    clear_stim();
    for (int c = 0; c < N; c++) begin
      s_enin[c] = 1'b1; s_nhold[c] = !(c >= 5 && c <= 7);
    end
    set_req(2, 1'b1, 1'b0);
    s_addr[2] = 16'h0FFE; s_wdata[2] = 8'h3C;
    model_txn(2, d);
    run_tables();
    for (int c = 0; c < N; c++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++; $display("FAIL write_hold cyc=%0d got=%h exp=%h", c, o & m, e & m);
      end
    end
    st_q.delete();
  endtask

  task automatic test_waitbus();
    int d;
    logic [W-1:0] o, e, m;
    clear_stim();
    for (int c = 0; c < N; c++) s_enin[c] = !(c >= 3 && c <= 6);
    set_req(2, 1'($urandom_range(0, 1)), 1'b0);
    model_txn(2, d);
    run_tables();
    for (int c = 0; c < N; c++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++; $display("FAIL waitbus cyc=%0d got=%h exp=%h", c, o & m, e & m);
      end
    end
    st_q.delete();
  endtask

  task automatic test_both_and_addr_only();
    int d;
    logic [W-1:0] o, e, m;
    for (int pass = 0; pass < 2; pass++) begin
      clear_stim();
      if (pass == 0) set_req(3, 1'b0, 1'b0);
      else           set_req(3, 1'b1, 1'b1);
      model_txn(3, d);
      run_tables();
      for (int c = 0; c < N; c++) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
        checks++;
        if ((o & m) !== (e & m)) begin
          failures++; $display("FAIL both_adronly p=%0d cyc=%0d got=%h exp=%h", pass, c, o & m, e & m);
        end
      end
      st_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [W-1:0] o, e, m;
    for (int it = 0; it < 3; it++) begin
      clear_stim();
      set_req(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model_txn(2, d1);
      set_req(d1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model_txn(d1, d2);
      run_tables();
      for (int c = 0; c < N; c++) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
        checks++;
        if ((o & m) !== (e & m)) begin
          failures++; $display("FAIL back_to_back it=%0d cyc=%0d got=%h exp=%h", it, c, o & m, e & m);
        end
      end
      st_q.delete();
    end
  endtask

  task automatic test_random_ignored();
    int d, c0;
    logic [W-1:0] o, e, m;
    for (int it = 0; it < 6; it++) begin
      clear_stim();
      c0 = int'($urandom_range(1, 3));
      set_req(c0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      // stray requests while the cycle is busy must be ignored
      s_ads_n[c0+1] = 1'b0;
      s_ads_n[c0+2] = 1'($urandom_range(0, 1));
      model_txn(c0, d);
      run_tables();
      for (int c = 0; c < N; c++) begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
        checks++;
        if ((o & m) !== (e & m)) begin
          failures++; $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, c, o & m, e & m);
        end
      end
      st_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] o, e, m;
    state_e st;
    rd_carry = 8'h00;
    clear_stim();
    for (int c = 0; c < N; c++) begin
      s_enin[c] = 1'b1; s_nhold[c] = 1'b1;
    end
    set_req(2, 1'b0, 1'b1);
    s_rst[5] = 1'b1;
    run_tables();
    for (int c = 0; c < N; c++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front(); st = st_q.pop_front();
      if (c >= 6) begin
        checks++;
        if ((o & m) !== (e & m)) begin
          failures++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, o & m, e & m);
        end
      end
      if (c == 6) begin
        checks++;
        if (st !== IDLE) begin
          failures++; $display("FAIL reset_mid_state got=%0d exp=%0d", st, IDLE);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_hold();
    test_waitbus();
    test_both_and_addr_only();
    test_back_to_back();
    test_random_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
